mul_arb_rr: RTL and testbench

Round-robin controller that shares one signed multiplier (A_WIDTH × B_WIDTH → P_WIDTH) among NUM_REQ requesters. It sits between the HLS kernel's parallel operand producers and a single result consumer. Each requester gets a valid/ready operand port. Results come back through one tagged response port, with one issue per cycle, two-cycle latency and full backpressure.

---
 rtl/mul_arb_pkg.sv | 31 +++
 rtl/mul_arb_smul.sv | 48 ++++
 rtl/mul_arb_rr.sv | 135 +++++++++++++
 tb/tb_mul_arb_rr.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared constants, id-width helper and pipeline record types
// for the round-robin shared multiplier (mul_arb_rr).
package mul_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_A_WIDTH = 10;
    localparam int unsigned DEF_B_WIDTH = 4;
    localparam int unsigned DEF_P_WIDTH = 10;

    // Requester-index width; never narrower than one bit.
    function automatic int unsigned ID_W(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_ID_W = ID_W(DEF_NUM_REQ);

    // Stage-1 record at the default geometry: accepted operands and owner.
    typedef struct packed {
        logic signed [DEF_A_WIDTH-1:0] a;
        logic signed [DEF_B_WIDTH-1:0] b;
        logic [DEF_ID_W-1:0]           id;
    } s1_rec_t;

    // Stage-2 record at the default geometry: result, owner, overflow flag.
    typedef struct packed {
        logic signed [DEF_P_WIDTH-1:0] p;
        logic [DEF_ID_W-1:0]           id;
        logic                          ovf;
    } s2_rec_t;

endpackage

// File: rtl/mul_arb_smul.sv
// mul_arb_smul: combinational signed multiply with overflow detect.
// Optional clamp on overflow when MUL_ARB_SATURATE_EN is defined;
// otherwise the low P_WIDTH bits are returned (wrap).
module mul_arb_smul
    import mul_arb_pkg::*;
#(
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH = DEF_B_WIDTH,
    parameter int unsigned P_WIDTH = DEF_P_WIDTH
) (
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic signed [P_WIDTH-1:0] p,
    output logic                      ovf
);

    localparam int unsigned FW = A_WIDTH + B_WIDTH;

    logic signed [FW-1:0]        full;
    logic        [FW-P_WIDTH:0]  upper;

    // Full-width product and overflow: the bits above the result's sign bit must all match it.
    always_comb begin
        full  = FW'(a) * FW'(b);
        upper = full[FW-1:P_WIDTH-1];
        ovf   = !((&upper) || !(|upper));
    end

`ifdef MUL_ARB_SATURATE_EN
    localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Clamp toward the product's sign on overflow.
    always_comb begin
        if (ovf) begin
            p = full[FW-1] ? P_MIN : P_MAX;
        end else begin
            p = full[P_WIDTH-1:0];
        end
    end
`else
    // Wrap: keep the low result bits.
    always_comb begin
        p = full[P_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/mul_arb_rr.sv
// mul_arb_rr: round-robin arbiter sharing one signed multiplier among
// NUM_REQ valid/ready requesters; two-stage pipeline with tagged response.
// Optional feature macro: MUL_ARB_SATURATE_EN (saturate rsp_p on overflow).
module mul_arb_rr
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH = DEF_B_WIDTH,
    parameter int unsigned P_WIDTH = DEF_P_WIDTH
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]    req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W(NUM_REQ)-1:0]      rsp_id,
    output logic signed [P_WIDTH-1:0]     rsp_p,
    output logic                          rsp_ovf,
    output logic                          busy
);

    localparam int unsigned IW = ID_W(NUM_REQ);

    typedef struct packed {
        logic signed [A_WIDTH-1:0] a;
        logic signed [B_WIDTH-1:0] b;
        logic [IW-1:0]             id;
    } s1_t;

    typedef struct packed {
        logic signed [P_WIDTH-1:0] p;
        logic [IW-1:0]             id;
        logic                      ovf;
    } s2_t;

    logic                      v1, v2;
    s1_t                       s1_q, s1_d;
    s2_t                       s2_q;
    logic [IW-1:0]             ptr;
    logic [IW-1:0]             cand;
    logic [IW-1:0]             gnt_idx;
    logic                      gnt_found;
    logic                      adv1, adv2, xfer;
    logic signed [P_WIDTH-1:0] mul_p;
    logic                      mul_ovf;

    // Stage advance: S2 drains when empty or consumed, S1 when empty or S2 advances.
    always_comb begin
        adv2 = !v2 || rsp_ready;
        adv1 = !v1 || adv2;
    end

    // Cyclic search for the first valid requester at or after ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // One-hot ready for the winner and operand selection into the S1 record.
    always_comb begin
        req_ready = '0;
        s1_d      = '0;
        xfer      = adv1 && gnt_found;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == gnt_idx) begin
                s1_d.a = req_a[i*A_WIDTH +: A_WIDTH];
                s1_d.b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
        s1_d.id = gnt_idx;
    end

    mul_arb_smul #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .P_WIDTH (P_WIDTH)
    ) u_smul (
        .a   (s1_q.a),
        .b   (s1_q.b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    // Pipeline registers and round-robin pointer; reset flushes in-flight work.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            ptr  <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2_q <= '{p: mul_p, id: s1_q.id, ovf: mul_ovf};
                end
            end
            if (adv1) begin
                v1 <= xfer;
                if (xfer) begin
                    s1_q <= s1_d;
                end
            end
            if (xfer) begin
                ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Response port is a straight view of S2.
    always_comb begin
        rsp_valid = v2;
        rsp_id    = s2_q.id;
        rsp_p     = s2_q.p;
        rsp_ovf   = s2_q.ovf;
        busy      = v1 || v2;
    end

endmodule

// File: tb/tb_mul_arb_rr.sv
// tb_mul_arb_rr: directed self-checking bench for mul_arb_rr (default geometry).
module tb_mul_arb_rr;

    logic        ap_clk;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [39:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [9:0]  rsp_p;
    logic        rsp_ovf;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef MUL_ARB_SATURATE_EN
    localparam logic [9:0] EXP_POS_OVF = 10'h1FF;
    localparam logic [9:0] EXP_NEG_OVF = 10'h200;
`else
    localparam logic [9:0] EXP_POS_OVF = 10'h178;
    localparam logic [9:0] EXP_NEG_OVF = 10'h224;
`endif

    logic [3:0] vtab [5] = '{4'b1010, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    int         gtab [5] = '{3, 0, 1, 3, 0};

    mul_arb_rr #(
        .NUM_REQ (4),
        .A_WIDTH (10),
        .B_WIDTH (4),
        .P_WIDTH (10)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [9:0] a, input logic [3:0] b);
        req_valid[i]       = v;
        req_a[i*10 +: 10]  = a;
        req_b[i*4 +: 4]    = b;
    endtask

    task automatic single(input int i, input logic [9:0] a, input logic [3:0] b,
                          input logic [9:0] ep, input logic eo, input string tag);
        set_req(i, 1'b1, a, b);
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << i));
        tick();
        set_req(i, 1'b0, a, b);
        #1;
        chk({tag, "_s1_busy_valid"}, 32'({busy, rsp_valid}), 32'(2'b10));
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1'b1));
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'(i));
        chk({tag, "_rsp_p"},     32'(rsp_p),     32'(ep));
        chk({tag, "_rsp_ovf"},   32'(rsp_ovf),   32'(eo));
        tick();
        chk({tag, "_drained"},   32'(rsp_valid), 32'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ap_rst    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        chk("rst_rsp_id",    32'(rsp_id),    32'(2'd0));
        chk("rst_rsp_p",     32'(rsp_p),     32'(10'd0));
        chk("rst_rsp_ovf",   32'(rsp_ovf),   32'(1'b0));
        chk("rst_busy",      32'(busy),      32'(1'b0));
        chk("rst_req_ready", 32'(req_ready), 32'(4'b0000));

        // 25 * -3 = -75
        single(0, 10'h019, 4'hD, 10'h3B5, 1'b0, "single");

        // Fill both stages (ptr=1), then reset mid-operation.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 10'(10 * (i + 1)), 4'h2);
        #1;
        chk("mid_ready0", 32'(req_ready), 32'(4'b0010));
        tick();
        chk("mid_ready1", 32'(req_ready), 32'(4'b0100));
        tick();
        chk("mid_full_valid", 32'(rsp_valid), 32'(1'b1));
        chk("mid_full_id",    32'(rsp_id),    32'(2'd1));
        chk("mid_full_p",     32'(rsp_p),     32'(10'd40));
        chk("mid_full_busy",  32'(busy),      32'(1'b1));
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'(1'b0));
        chk("mid_rst_busy",  32'(busy),      32'(1'b0));
        chk("mid_rst_p",     32'(rsp_p),     32'(10'd0));
        chk("mid_rst_ready", 32'(req_ready), 32'(4'b0001));

        // All four requesters continuously valid: grants 0,1,2,3,0,...
        for (int c = 0; c < 8; c++) begin
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            if (c >= 2) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(1'b1));
                chk("rr_rsp_id",    32'(rsp_id),    32'((c - 2) % 4));
                chk("rr_rsp_p",     32'(rsp_p),     32'(20 * ((c - 2) % 4 + 1)));
            end
            tick();
        end
        req_valid = '0;
        #1;
        chk("rr_tail_id0", 32'(rsp_id), 32'(2'd2));
        chk("rr_tail_p0",  32'(rsp_p),  32'(10'd60));
        tick();
        chk("rr_tail_id1", 32'(rsp_id), 32'(2'd3));
        chk("rr_tail_p1",  32'(rsp_p),  32'(10'd80));
        tick();
        chk("rr_idle_valid", 32'(rsp_valid), 32'(1'b0));
        chk("rr_idle_busy",  32'(busy),      32'(1'b0));

        // 200 * 7 = 1400 and -300 * 5 = -1500, both overflow 10 bits.
        single(2, 10'h0C8, 4'h7, EXP_POS_OVF, 1'b1, "ovf_pos");
        single(1, 10'h2D4, 4'h5, EXP_NEG_OVF, 1'b1, "ovf_neg");

        // ptr=2 with requesters 1 and 3; requester 0 joins mid-stream.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(i + 1), 4'h1);
        for (int c = 0; c < 5; c++) begin
            req_valid = vtab[c];
            #1;
            chk("sparse_ready", 32'(req_ready), 32'(4'b0001 << gtab[c]));
            if (c >= 2) chk("sparse_rsp_id", 32'(rsp_id), 32'(gtab[c - 2]));
            tick();
        end
        req_valid = '0;
        #1;
        chk("sparse_tail_id0", 32'(rsp_id), 32'(2'd3));
        chk("sparse_tail_p0",  32'(rsp_p),  32'(10'd4));
        tick();
        chk("sparse_tail_id1", 32'(rsp_id), 32'(2'd0));
        chk("sparse_tail_p1",  32'(rsp_p),  32'(10'd1));
        tick();
        chk("sparse_idle", 32'(rsp_valid), 32'(1'b0));

        // Backpressure: ptr=1, fill both stages, stall for three cycles.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 10'(i + 5), 4'h1);
        #1;
        chk("bp_ready0", 32'(req_ready), 32'(4'b0010));
        tick();
        chk("bp_ready1", 32'(req_ready), 32'(4'b0100));
        tick();
        rsp_ready = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("bp_stall_ready", 32'(req_ready), 32'(4'b0000));
            chk("bp_stall_valid", 32'(rsp_valid), 32'(1'b1));
            chk("bp_stall_id",    32'(rsp_id),    32'(2'd1));
            chk("bp_stall_p",     32'(rsp_p),     32'(10'd6));
            chk("bp_stall_busy",  32'(busy),      32'(1'b1));
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_id",    32'(rsp_id),    32'(2'd1));
        chk("bp_rel_ready", 32'(req_ready), 32'(4'b1000));
        tick();
        req_valid = '0;
        #1;
        chk("bp_out_id2", 32'(rsp_id), 32'(2'd2));
        chk("bp_out_p2",  32'(rsp_p),  32'(10'd7));
        tick();
        chk("bp_out_id3", 32'(rsp_id), 32'(2'd3));
        chk("bp_out_p3",  32'(rsp_p),  32'(10'd8));
        tick();
        chk("bp_end_valid", 32'(rsp_valid), 32'(1'b0));
        chk("bp_end_busy",  32'(busy),      32'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
